// File: rtl/layer_compositor.sv
// -----------------------------------------------------------------------------
// layer_compositor
//
// Merges NUM_LAYERS priority-ranked sprite layers and a full-screen overlay
// into one pixel stream. A frame-synchronous fade FSM cross-fades between
// gameplay and the overlay (game-over screen).
//
// Pipeline: select (p1) -> scale by fade level (p2 / outputs). The fixed
// latency from any input to pixel_out, active_out, fsync_out, hpos_out and
// vpos_out is 2 cycles.
//
// Optional feature macro: COMPOSITOR_BLEND_EN
//   defined   - a translucent top layer is averaged 50/50 with the next
//               active layer below it (or BG_COLOR if there is none).
//   undefined - layer_translucent is ignored; selection is pure priority.
//
// Ports
//   pixel_clk, rst_n          clock, asynchronous active-low reset
//   fsync                     one-cycle frame-start pulse
//   active_in                 active video region
//   hpos_in, vpos_in          signed pixel position
//   layer_pixel               layer k at [24k+23:24k], {red,green,blue}
//   layer_active              layer k covers the current pixel
//   layer_translucent         layer k requests a 50% blend (macro only)
//   overlay_pixel             overlay colour
//   overlay_req               level request to show the overlay
//   pixel_out                 composed colour
//   active_out, fsync_out     delayed to align with pixel_out
//   hpos_out, vpos_out        delayed to align with pixel_out
//   mode                      0=PLAY 1=FADE_OUT 2=OVERLAY 3=FADE_IN
//   fade_level                brightness 0..8
// -----------------------------------------------------------------------------
module layer_compositor #(
  parameter int          NUM_LAYERS  = 4,
  parameter int          FADE_FRAMES = 4,
  parameter logic [23:0] BG_COLOR    = 24'h000000
) (
  input  logic                      pixel_clk,
  input  logic                      rst_n,
  input  logic                      fsync,
  input  logic                      active_in,
  input  logic signed [11:0]        hpos_in,
  input  logic signed [11:0]        vpos_in,
  input  logic [24*NUM_LAYERS-1:0]  layer_pixel,
  input  logic [NUM_LAYERS-1:0]     layer_active,
  input  logic [NUM_LAYERS-1:0]     layer_translucent,
  input  logic [23:0]               overlay_pixel,
  input  logic                      overlay_req,
  output logic [23:0]               pixel_out,
  output logic                      active_out,
  output logic                      fsync_out,
  output logic signed [11:0]        hpos_out,
  output logic signed [11:0]        vpos_out,
  output logic [1:0]                mode,
  output logic [3:0]                fade_level
);

  localparam logic [1:0] ST_PLAY     = 2'd0;
  localparam logic [1:0] ST_FADE_OUT = 2'd1;
  localparam logic [1:0] ST_OVERLAY  = 2'd2;
  localparam logic [1:0] ST_FADE_IN  = 2'd3;

  localparam int          CNT_W    = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FADE_FRAMES - 1);

  // Per-channel (c * level) >> 3 on a 12-bit product; level 8 is identity.
  function automatic logic [23:0] scale_px(input logic [23:0] c, input logic [3:0] lvl);
    logic [11:0] prod;
    logic [23:0] res;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      prod = {4'b0, c[8*ch +: 8]} * {8'b0, lvl};
      res[8*ch +: 8] = prod[10:3];
    end
    return res;
  endfunction

  // Per-channel (a + b) >> 1 on a 9-bit sum.
  function automatic logic [23:0] avg_px(input logic [23:0] a, input logic [23:0] b);
    logic [8:0]  sum;
    logic [23:0] res;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum = {1'b0, a[8*ch +: 8]} + {1'b0, b[8*ch +: 8]};
      res[8*ch +: 8] = sum[8:1];
    end
    return res;
  endfunction

  // Fade FSM state
  logic [1:0]        mode_q,  mode_d;
  logic [3:0]        level_q, level_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;

  // Stage 1 registers
  logic [23:0]        pix_p1_q, pix_p1_d;
  logic               vld_p1_q;
  logic               fsync_p1_q;
  logic signed [11:0] hpos_p1_q, vpos_p1_q;

  // Stage 2 registers (outputs)
  logic [23:0]        pix_p2_q, pix_p2_d;
  logic               vld_p2_q;
  logic               fsync_p2_q;
  logic signed [11:0] hpos_p2_q, vpos_p2_q;

  // ---------------------------------------------------------------------------
  // Fade FSM. Transitions are evaluated on fsync only. The reversal and exit
  // checks look at the pre-step level; a coincident step is then applied in
  // the direction of the state being entered.
  // ---------------------------------------------------------------------------
  logic             step;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    mode_d  = mode_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    step    = (cnt_q == CNT_LAST);
    cnt_nxt = step ? '0 : cnt_q + 1'b1;
    if (fsync) begin
      case (mode_q)
        ST_PLAY: begin
          if (overlay_req) mode_d = ST_FADE_OUT;
        end
        ST_FADE_OUT: begin
          cnt_d = cnt_nxt;
          if (!overlay_req) begin
            mode_d = ST_FADE_IN;
            if (step && level_q < 4'd8) level_d = level_q + 4'd1;
          end else if (step) begin
            if (level_q <= 4'd1) begin
              mode_d  = ST_OVERLAY;
              level_d = 4'd8;
              cnt_d   = '0;
            end else begin
              level_d = level_q - 4'd1;
            end
          end
        end
        ST_OVERLAY: begin
          if (!overlay_req) begin
            mode_d  = ST_FADE_IN;
            level_d = 4'd0;
          end
        end
        default: begin // ST_FADE_IN
          cnt_d = cnt_nxt;
          if (overlay_req) begin
            mode_d = ST_FADE_OUT;
            if (step && level_q > 4'd0) level_d = level_q - 4'd1;
          end else if (level_q == 4'd8 || (step && level_q == 4'd7)) begin
            // level_q can already be 8 here only after a reversal step
            mode_d  = ST_PLAY;
            level_d = 4'd8;
            cnt_d   = '0;
          end else if (step) begin
            level_d = level_q + 4'd1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: select by active flag and priority (lowest index wins)
  // ---------------------------------------------------------------------------
  logic [23:0] top_px;
  logic        top_found;
`ifdef COMPOSITOR_BLEND_EN
  logic [23:0] under_px;
  logic        under_found;
  logic        top_tr;
`else
  logic        unused_transl;
  assign unused_transl = ^layer_translucent;
`endif

  always_comb begin
    top_px    = BG_COLOR;
    top_found = 1'b0;
`ifdef COMPOSITOR_BLEND_EN
    under_px    = BG_COLOR;
    under_found = 1'b0;
    top_tr      = 1'b0;
`endif
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (layer_active[k]) begin
        if (!top_found) begin
          top_found = 1'b1;
          top_px    = layer_pixel[24*k +: 24];
`ifdef COMPOSITOR_BLEND_EN
          top_tr    = layer_translucent[k];
`endif
        end
`ifdef COMPOSITOR_BLEND_EN
        else if (!under_found) begin
          under_found = 1'b1;
          under_px    = layer_pixel[24*k +: 24];
        end
`endif
      end
    end

    if (!active_in) begin
      pix_p1_d = '0;
    end else if (mode_q == ST_OVERLAY) begin
      pix_p1_d = overlay_pixel;
    end else begin
`ifdef COMPOSITOR_BLEND_EN
      pix_p1_d = (top_found && top_tr) ? avg_px(top_px, under_px) : top_px;
`else
      pix_p1_d = top_px;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: fade scaling
  // ---------------------------------------------------------------------------
  always_comb begin
    pix_p2_d = scale_px(pix_p1_q, level_q);
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= ST_PLAY;
      level_q    <= 4'd8;
      cnt_q      <= '0;
      pix_p1_q   <= '0;
      vld_p1_q   <= 1'b0;
      fsync_p1_q <= 1'b0;
      hpos_p1_q  <= '0;
      vpos_p1_q  <= '0;
      pix_p2_q   <= '0;
      vld_p2_q   <= 1'b0;
      fsync_p2_q <= 1'b0;
      hpos_p2_q  <= '0;
      vpos_p2_q  <= '0;
    end else begin
      mode_q     <= mode_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      pix_p1_q   <= pix_p1_d;
      vld_p1_q   <= active_in;
      fsync_p1_q <= fsync;
      hpos_p1_q  <= hpos_in;
      vpos_p1_q  <= vpos_in;
      pix_p2_q   <= pix_p2_d;
      vld_p2_q   <= vld_p1_q;
      fsync_p2_q <= fsync_p1_q;
      hpos_p2_q  <= hpos_p1_q;
      vpos_p2_q  <= vpos_p1_q;
    end
  end

  assign pixel_out  = pix_p2_q;
  assign active_out = vld_p2_q;
  assign fsync_out  = fsync_p2_q;
  assign hpos_out   = hpos_p2_q;
  assign vpos_out   = vpos_p2_q;
  assign mode       = mode_q;
  assign fade_level = level_q;

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

  localparam logic [23:0] BG = 24'h203040;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               fsync;
  logic               active_in;
  logic signed [11:0] hpos_in, vpos_in;
  logic [95:0]        layer_pixel;
  logic [3:0]         layer_active;
  logic [3:0]         layer_translucent;
  logic [23:0]        overlay_pixel;
  logic               overlay_req;
  logic [23:0]        pixel_out;
  logic               active_out, fsync_out;
  logic signed [11:0] hpos_out, vpos_out;
  logic [1:0]         mode;
  logic [3:0]         fade_level;

  int n_cmp = 0;
  int n_bad = 0;

  layer_compositor #(
    .NUM_LAYERS (4),
    .FADE_FRAMES(4),
    .BG_COLOR   (BG)
  ) dut (
    .pixel_clk        (clk),
    .rst_n            (rst_n),
    .fsync            (fsync),
    .active_in        (active_in),
    .hpos_in          (hpos_in),
    .vpos_in          (vpos_in),
    .layer_pixel      (layer_pixel),
    .layer_active     (layer_active),
    .layer_translucent(layer_translucent),
    .overlay_pixel    (overlay_pixel),
    .overlay_req      (overlay_req),
    .pixel_out        (pixel_out),
    .active_out       (active_out),
    .fsync_out        (fsync_out),
    .hpos_out         (hpos_out),
    .vpos_out         (vpos_out),
    .mode             (mode),
    .fade_level       (fade_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] pix;
    logic [3:0]  act;
    logic [3:0]  tr;
    logic        ain;
    logic [11:0] h;
    logic [11:0] v;
    logic [23:0] exp;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame: fsync pulse, then enough cycles to flush the pixel pipeline.
  task automatic frame();
    fsync = 1'b1;
    tick(1);
    fsync = 1'b0;
    tick(3);
  endtask

  task automatic chk_fsm(input string name, input logic [1:0] m, input logic [3:0] l);
    chk({name, "_mode"}, {30'b0, mode}, {30'b0, m});
    chk({name, "_level"}, {28'b0, fade_level}, {28'b0, l});
  endtask

  initial begin
    // {L3, L2, L1, L0}
    tv[0] = '{{24'hFF0000, 24'h000000, 24'h00FF00, 24'h000000}, 4'b1010, 4'b0000, 1'b1, 12'd10,  12'd20,  24'h00FF00};
    tv[1] = '{{24'h000000, 24'hFFFFFF, 24'h000000, 24'h000000}, 4'b0101, 4'b0000, 1'b1, 12'hFFD, 12'd5,   24'h000000};
    tv[2] = '{{24'h111111, 24'h222222, 24'h333333, 24'h444444}, 4'b0000, 4'b0000, 1'b1, 12'd100, 12'd200, BG};
    tv[3] = '{{24'h000000, 24'h000000, 24'h000000, 24'hAABBCC}, 4'b0001, 4'b0000, 1'b0, 12'd7,   12'hFFF, 24'h000000};
    tv[4] = '{{24'h123456, 24'h000000, 24'h000000, 24'h000000}, 4'b1000, 4'b0000, 1'b1, 12'd1,   12'd2,   24'h123456};
    tv[5] = '{{24'h010203, 24'h040506, 24'h070809, 24'hFEDCBA}, 4'b1111, 4'b0000, 1'b1, 12'h800, 12'h7FF, 24'hFEDCBA};
    tv[6] = '{{24'hABCDEF, 24'h0F0F0F, 24'h000000, 24'h000000}, 4'b1100, 4'b0000, 1'b1, 12'd33,  12'd44,  24'h0F0F0F};

    rst_n = 1'b0; fsync = 1'b0; active_in = 1'b0; hpos_in = '0; vpos_in = '0;
    layer_pixel = '0; layer_active = '0; layer_translucent = '0;
    overlay_pixel = 24'h5A6B7C; overlay_req = 1'b0;
    tick(2);
    chk("rst_pixel", {8'b0, pixel_out}, 32'h0);
    chk("rst_active", {31'b0, active_out}, 32'h0);
    chk("rst_fsync", {31'b0, fsync_out}, 32'h0);
    chk("rst_hpos", {20'b0, hpos_out[11:0]}, 32'h0);
    chk_fsm("rst", 2'd0, 4'd8);
    rst_n = 1'b1;
    tick(3);

    // Latency: nothing new after one edge, result after two.
    layer_pixel = tv[0].pix; layer_active = tv[0].act; active_in = tv[0].ain;
    hpos_in = tv[0].h; vpos_in = tv[0].v;
    tick(1);
    chk("lat1_pixel", {8'b0, pixel_out}, 32'h0);
    tick(1);
    chk("lat2_pixel", {8'b0, pixel_out}, {8'b0, tv[0].exp});

    for (int i = 0; i < 7; i++) begin
      layer_pixel = tv[i].pix; layer_active = tv[i].act; layer_translucent = tv[i].tr;
      active_in = tv[i].ain; hpos_in = tv[i].h; vpos_in = tv[i].v;
      tick(2);
      chk($sformatf("vec%0d_pixel", i), {8'b0, pixel_out}, {8'b0, tv[i].exp});
      chk($sformatf("vec%0d_active", i), {31'b0, active_out}, {31'b0, tv[i].ain});
      chk($sformatf("vec%0d_hpos", i), {20'b0, hpos_out[11:0]}, {20'b0, tv[i].h});
      chk($sformatf("vec%0d_vpos", i), {20'b0, vpos_out[11:0]}, {20'b0, tv[i].v});
    end

    // Translucent layer handling
    active_in = 1'b1;
    layer_pixel = {24'h0, 24'h0, 24'h0000FF, 24'hFF0000};
    layer_active = 4'b0011; layer_translucent = 4'b0001;
    tick(2);
`ifdef COMPOSITOR_BLEND_EN
    chk("blend_l1", {8'b0, pixel_out}, 32'h007F007F);
`else
    chk("blend_l1", {8'b0, pixel_out}, 32'h00FF0000);
`endif
    layer_pixel = {24'h0, 24'h808080, 24'h0, 24'h0};
    layer_active = 4'b0100; layer_translucent = 4'b0100;
    tick(2);
`ifdef COMPOSITOR_BLEND_EN
    chk("blend_bg", {8'b0, pixel_out}, 32'h00505860);
`else
    chk("blend_bg", {8'b0, pixel_out}, 32'h00808080);
`endif
    layer_translucent = 4'b0000;

    // fsync alignment; no request, so PLAY is kept
    fsync = 1'b1;
    tick(1);
    fsync = 1'b0;
    chk("fsync_d1", {31'b0, fsync_out}, 32'h0);
    tick(1);
    chk("fsync_d2", {31'b0, fsync_out}, 32'h1);
    tick(1);
    chk("fsync_d3", {31'b0, fsync_out}, 32'h0);
    chk_fsm("play_hold", 2'd0, 4'd8);

    // Full fade out to the overlay
    layer_pixel = {72'h0, 24'hC8C8C8}; layer_active = 4'b0001;
    overlay_req = 1'b1;
    frame();
    chk_fsm("fo_enter", 2'd1, 4'd8);
    for (int s = 1; s <= 8; s++) begin
      repeat (4) frame();
      if (s < 8) chk_fsm($sformatf("fo_step%0d", s), 2'd1, 4'(8 - s));
      if (s == 1) chk("fo_px_l7", {8'b0, pixel_out}, 32'h00AFAFAF);
      if (s == 4) chk("fo_px_l4", {8'b0, pixel_out}, 32'h00646464);
    end
    chk_fsm("overlay", 2'd2, 4'd8);
    chk("overlay_px", {8'b0, pixel_out}, 32'h005A6B7C);
    overlay_req = 1'b0;
    frame();
    chk_fsm("ov_to_fi", 2'd3, 4'd0);
    chk("fi_px_l0", {8'b0, pixel_out}, 32'h0);

    // Reversal during fade out at level 5
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    overlay_req = 1'b1;
    frame();
    repeat (12) frame();
    chk_fsm("rev_l5", 2'd1, 4'd5);
    chk("rev_px_l5", {8'b0, pixel_out}, 32'h007D7D7D);
    overlay_req = 1'b0;
    frame();
    chk_fsm("rev_fi", 2'd3, 4'd5);
    repeat (3) frame();
    chk_fsm("rev_l6", 2'd3, 4'd6);
    chk("rev_px_l6", {8'b0, pixel_out}, 32'h00969696);
    repeat (4) frame();
    chk_fsm("rev_l7", 2'd3, 4'd7);
    repeat (4) frame();
    chk_fsm("rev_play", 2'd0, 4'd8);
    chk("rev_px_l8", {8'b0, pixel_out}, 32'h00C8C8C8);

    // Asynchronous reset while in OVERLAY
    hpos_in = 12'd77; vpos_in = 12'd88;
    overlay_req = 1'b1;
    repeat (33) frame();
    chk_fsm("ar_overlay", 2'd2, 4'd8);
    chk("ar_pre_hpos", {20'b0, hpos_out[11:0]}, 32'd77);
    #2 rst_n = 1'b0;
    #1;
    chk_fsm("ar", 2'd0, 4'd8);
    chk("ar_pixel", {8'b0, pixel_out}, 32'h0);
    chk("ar_active", {31'b0, active_out}, 32'h0);
    chk("ar_hpos", {20'b0, hpos_out[11:0]}, 32'h0);
    chk("ar_vpos", {20'b0, vpos_out[11:0]}, 32'h0);
    overlay_req = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk_fsm("ar_after", 2'd0, 4'd8);
    chk("ar_after_px", {8'b0, pixel_out}, 32'h00C8C8C8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
